// File: rtl/elbeth_arb_pkg.sv
// Shared definitions for the elbeth memory arbiter: FSM encoding, requester
// IDs and the read-access byte mask.
package elbeth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [3:0] RW_READ = 4'b0000;

endpackage

// File: rtl/elbeth_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright; on a tie the
// requester that was not served last wins. Purely combinational.
module elbeth_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  import elbeth_arb_pkg::*;

  // Resolve one-hot grant from the request pair and the last-served ID
  always_comb begin
    gnt = '0;
    if (req[PORT_I] && req[PORT_D]) begin
      if (last == PORT_I) begin
        gnt[PORT_D] = 1'b1;
      end else begin
        gnt[PORT_I] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Arbitrates an instruction and a data requester onto one single-port memory.
// Optional access timeout enabled by defining ELBETH_ARB_TIMEOUT_EN; without
// it BUSY waits for mem_ready indefinitely and the error outputs are tied low.
module elbeth_mem_arbiter #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_rw,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_error,

  input  logic              d_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_rw,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_error,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  import elbeth_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_rw_q, mem_rw_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [1:0]        gnt;

`ifdef ELBETH_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_error_q, i_error_d;
  logic              d_error_q, d_error_d;
`endif

  elbeth_rr_arb2 u_rr (
    .req  ({d_en, i_en}),
    .last (last_q),
    .gnt  (gnt)
  );

  // State and datapath registers; reset also aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_I;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= RW_READ;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef ELBETH_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      i_error_q   <= 1'b0;
      d_error_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef ELBETH_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      i_error_q   <= i_error_d;
      d_error_q   <= d_error_d;
`endif
    end
  end

  // Next-state: grant from IDLE, hold request fields while BUSY, complete on mem_ready
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = mem_rw_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
`ifdef ELBETH_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    i_error_d   = 1'b0;
    d_error_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (gnt[PORT_D]) begin
          state_d     = BUSY_D;
          last_d      = PORT_D;
          mem_en_d    = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_rw_d    = d_rw;
        end else if (gnt[PORT_I]) begin
          state_d     = BUSY_I;
          last_d      = PORT_I;
          mem_en_d    = 1'b1;
          mem_addr_d  = i_addr;
          mem_wdata_d = i_wdata;
          mem_rw_d    = i_rw;
        end
`ifdef ELBETH_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end
        end
`ifdef ELBETH_ARB_TIMEOUT_EN
        // Late mem_ready on the final allowed edge still wins over the timeout
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_ready_d = 1'b1;
            d_error_d = 1'b1;
          end else begin
            i_ready_d = 1'b1;
            i_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

`ifdef ELBETH_ARB_TIMEOUT_EN
  assign i_error   = i_error_q;
  assign d_error   = d_error_q;
`else
  assign i_error   = 1'b0;
  assign d_error   = 1'b0;
`endif

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Self-checking bench for elbeth_mem_arbiter: directed scenarios plus a
// randomized two-requester run against a transaction-level memory model.
module tb_elbeth_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          clk, rst;
  logic          i_en, d_en;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [3:0]    i_rw, d_rw;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready, i_error, d_error;
  logic          mem_en, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_rw;

  elbeth_mem_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rw      (i_rw),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .i_error   (i_error),
    .d_en      (d_en),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rw      (d_rw),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .d_error   (d_error),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  int          mem_fixed_lat;
  int          busy_cnt;
  int          cur_lat;
  bit          mon_en;
  logic        mon_last;
  logic        prev_i_en, prev_d_en, prev_mem_en;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic [3:0]    prev_rw;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers after cur_lat wait cycles, returns old contents, applies byte writes
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    busy_cnt  = 0;
    cur_lat   = 0;
    forever begin
      tick();
      if (mem_en) begin
        if (busy_cnt == 0)
          cur_lat = (mem_fixed_lat < 0) ? int'($urandom_range(0, 3)) : mem_fixed_lat;
        if (busy_cnt == cur_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_arr[mem_addr];
          for (int b = 0; b < 4; b++)
            if (mem_rw[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        busy_cnt++;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        busy_cnt  = 0;
      end
    end
  end

  // Bus monitor: round-robin grant rule, mem_* hold while busy, ready exclusivity
  initial begin
    logic gp, exp_p;
    prev_i_en = 1'b0; prev_d_en = 1'b0; prev_mem_en = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_rw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mon_en && mem_en && !prev_mem_en) begin
          gp    = mem_addr[7];
          exp_p = (prev_i_en && prev_d_en) ? ~mon_last : prev_d_en;
          n_run++;
          if (!(prev_i_en || prev_d_en) || gp !== exp_p) begin
            n_fail++;
            $display("FAIL arb_grant: granted port %0d, required port %0d (i_en=%b d_en=%b)",
                     gp, exp_p, prev_i_en, prev_d_en);
          end
          mon_last = gp;
        end
        if (mem_en && prev_mem_en) begin
          n_run++;
          if ({mem_addr, mem_wdata, mem_rw} !== {prev_addr, prev_wdata, prev_rw}) begin
            n_fail++;
            $display("FAIL mem_hold: got %h/%h/%b, required %h/%h/%b",
                     mem_addr, mem_wdata, mem_rw, prev_addr, prev_wdata, prev_rw);
          end
        end
        if (i_ready || d_ready) begin
          n_run++;
          if (i_ready && d_ready) begin
            n_fail++;
            $display("FAIL ready_excl: i_ready=%b d_ready=%b, required not both", i_ready, d_ready);
          end
        end
      end
      prev_i_en   = i_en;
      prev_d_en   = d_en;
      prev_mem_en = mem_en;
      prev_addr   = mem_addr;
      prev_wdata  = mem_wdata;
      prev_rw     = mem_rw;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    i_en = 1'b0; i_addr = '0; i_wdata = '0; i_rw = '0;
    d_en = 1'b0; d_addr = '0; d_wdata = '0; d_rw = '0;
    mon_last = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_run++; if (mem_en !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
    n_run++; if (mem_addr !== '0)  begin n_fail++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
    n_run++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    n_run++; if (mem_rw !== 4'b0)  begin n_fail++; $display("FAIL rst_mem_rw: got %b required 0", mem_rw); end
    n_run++; if ({i_ready, d_ready, i_error, d_error} !== 4'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b required 0000", {i_ready, d_ready, i_error, d_error});
    end
    n_run++; if (i_rdata !== '0) begin n_fail++; $display("FAIL rst_i_rdata: got %h required 0", i_rdata); end
    n_run++; if (d_rdata !== '0) begin n_fail++; $display("FAIL rst_d_rdata: got %h required 0", d_rdata); end
    rst = 1'b1;
    repeat (2) tick();
    n_run++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: mem_en got %b required 0", mem_en); end
  endtask

  task automatic test_single_read();
    do_reset();
    mem_fixed_lat  = 0;
    mem_arr[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    d_en = 1'b1; d_addr = 8'h10; d_rw = 4'b0000; d_wdata = $urandom;
    tick();
    n_run++; if ({mem_en, mem_addr, mem_rw} !== {1'b1, 8'h10, 4'b0000}) begin
      n_fail++; $display("FAIL single_grant: en/addr/rw got %b/%h/%b required 1/10/0000", mem_en, mem_addr, mem_rw);
    end
    tick();
    n_run++; if ({d_ready, d_error, i_ready} !== 3'b100) begin
      n_fail++; $display("FAIL single_ready: d_ready/d_error/i_ready got %b required 100", {d_ready, d_error, i_ready});
    end
    n_run++; if (d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h required deadbeef", d_rdata); end
    d_en = 1'b0;
    tick();
    n_run++; if ({d_ready, i_ready, mem_en} !== 3'b000) begin
      n_fail++; $display("FAIL single_pulse: d_ready/i_ready/mem_en got %b required 000", {d_ready, i_ready, mem_en});
    end
    n_run++; if (d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %h required deadbeef", d_rdata); end
  endtask

  task automatic test_latency();
    int slots;
    for (int w = 1; w <= 3; w++) begin
      mem_fixed_lat = w;
      d_en = 1'b1; d_addr = 8'(8'h20 + w); d_rw = 4'b0000;
      slots = 0;
      do begin tick(); slots++; end while (!d_ready && slots < 20);
      n_run++; if (slots !== w + 2) begin
        n_fail++; $display("FAIL latency_w%0d: ready after %0d cycles required %0d", w, slots, w + 2);
      end
      n_run++; if (d_rdata !== ref_mem[d_addr]) begin
        n_fail++; $display("FAIL latency_rdata_w%0d: got %h required %h", w, d_rdata, ref_mem[d_addr]);
      end
      d_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_tie();
    int d_slot, i_slot, d_cnt, i_cnt;
    logic [31:0] d_got, i_got;
    do_reset();
    mem_fixed_lat = 0;
    d_slot = -1; i_slot = -1; d_cnt = 0; i_cnt = 0; d_got = '0; i_got = '0;
    i_en = 1'b1; i_addr = 8'h20; i_rw = 4'b0000;
    d_en = 1'b1; d_addr = 8'h30; d_rw = 4'b0000;
    for (int s = 1; s <= 10; s++) begin
      tick();
      if (d_ready) begin d_cnt++; if (d_slot < 0) d_slot = s; d_got = d_rdata; d_en = 1'b0; end
      if (i_ready) begin i_cnt++; if (i_slot < 0) i_slot = s; i_got = i_rdata; i_en = 1'b0; end
    end
    n_run++; if (d_slot !== 2) begin n_fail++; $display("FAIL tie_d_first: d_ready at cycle %0d required 2", d_slot); end
    n_run++; if (i_slot !== 4) begin n_fail++; $display("FAIL tie_i_second: i_ready at cycle %0d required 4", i_slot); end
    n_run++; if ({d_cnt, i_cnt} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL tie_pulses: d=%0d i=%0d pulses required 1 each", d_cnt, i_cnt);
    end
    n_run++; if ({d_got, i_got} !== {ref_mem[8'h30], ref_mem[8'h20]}) begin
      n_fail++; $display("FAIL tie_rdata: got %h/%h required %h/%h", d_got, i_got, ref_mem[8'h30], ref_mem[8'h20]);
    end
  endtask

  task automatic test_write();
    int slots, bad;
    logic [31:0] old;
    do_reset();
    mem_fixed_lat = 3;
    old = ref_mem[8'h40];
    i_en = 1'b1; i_addr = 8'h40; i_wdata = 32'h12345678; i_rw = 4'b1111;
    tick();
    slots = 1; bad = 0;
    i_addr = 8'h41; i_wdata = $urandom; i_rw = 4'b0000;
    while (!i_ready && slots < 20) begin
      if ({mem_en, mem_addr, mem_wdata, mem_rw} !== {1'b1, 8'h40, 32'h12345678, 4'b1111}) bad++;
      tick();
      slots++;
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL write_hold: %0d cycles with wrong mem fields, required 0", bad); end
    n_run++; if (slots !== 5) begin n_fail++; $display("FAIL write_latency: ready after %0d cycles required 5", slots); end
    n_run++; if (i_rdata !== old) begin n_fail++; $display("FAIL write_rdata: got %h required %h", i_rdata, old); end
    i_en = 1'b0;
    ref_mem[8'h40] = 32'h12345678;
    mem_fixed_lat = 0;
    tick();
    d_en = 1'b1; d_addr = 8'h40; d_rw = 4'b0000;
    tick(); tick();
    n_run++; if ({d_ready, d_rdata} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL write_readback: ready/data got %b/%h required 1/12345678", d_ready, d_rdata);
    end
    d_en = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    int i_grants, i_cnt;
    do_reset();
    mem_fixed_lat = 0;
    i_grants = 0; i_cnt = 0;
    i_en = 1'b1; i_addr = 8'h06; i_rw = 4'b0000;
    d_en = 1'b1; d_addr = 8'h86; d_rw = 4'b0000;
    tick();
    i_en = 1'b0;
    n_run++; if (mem_addr !== 8'h86) begin n_fail++; $display("FAIL withdraw_d_grant: mem_addr %h required 86", mem_addr); end
    for (int s = 2; s <= 8; s++) begin
      tick();
      if (d_ready) d_en = 1'b0;
      if (i_ready) i_cnt++;
      if (mem_en && mem_addr == 8'h06) i_grants++;
    end
    n_run++; if ({i_grants, i_cnt} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL withdraw_no_access: i grants=%0d readies=%0d required 0/0", i_grants, i_cnt);
    end
  endtask

  task automatic test_alternation();
    logic seq [$];
    bit   d_gap;
    int   s;
    do_reset();
    mem_fixed_lat = 0;
    mon_en = 1'b1;
    d_gap = 1'b0;
    i_en = 1'b1; i_addr = 8'h05; i_rw = 4'b0000;
    d_en = 1'b1; d_addr = 8'h85; d_rw = 4'b0000;
    s = 0;
    while (seq.size() < 12 && s < 200) begin
      tick(); s++;
      if (d_ready) begin seq.push_back(1'b1); d_en = 1'b0; d_gap = 1'b1; end
      else if (d_gap) begin d_en = 1'b1; d_gap = 1'b0; end
      if (i_ready) seq.push_back(1'b0);
    end
    n_run++; if (seq.size() !== 12) begin n_fail++; $display("FAIL alt_count: %0d completions required 12", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      n_run++;
      if (seq[k] !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL alt_order: completion %0d from port %0d required %0d", k, seq[k], (k % 2) == 0);
      end
    end
    i_en = 1'b0; d_en = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_reset();
    mem_fixed_lat = 0;
    d_en = 1'b1; d_addr = 8'h10; d_rw = 4'b0000;
    tick(); tick();
    d_en = 1'b0;
    tick();
    mem_fixed_lat = 3;
    d_en = 1'b1; d_addr = 8'h12;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_run++; if ({mem_en, d_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_immediate: mem_en/d_ready got %b required 00", {mem_en, d_ready});
    end
    n_run++; if (d_rdata !== '0) begin n_fail++; $display("FAIL abort_rdata_clr: got %h required 0", d_rdata); end
    d_en = 1'b0;
    pulses = 0;
    for (int s = 0; s < 3; s++) begin tick(); if (d_ready || mem_en) pulses++; end
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin tick(); if (d_ready || mem_en) pulses++; end
    n_run++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles required 0", pulses); end
    mem_fixed_lat = 0;
    d_en = 1'b1; d_addr = 8'h13;
    tick(); tick();
    n_run++; if ({d_ready, d_rdata} !== {1'b1, ref_mem[8'h13]}) begin
      n_fail++; $display("FAIL abort_recover: ready/data got %b/%h required 1/%h", d_ready, d_rdata, ref_mem[8'h13]);
    end
    d_en = 1'b0;
    tick();
  endtask

`ifdef ELBETH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int slots, not_busy;
    do_reset();
    mem_fixed_lat = 1_000_000;
    d_en = 1'b1; d_addr = 8'h14; d_rw = 4'b0000;
    slots = 0; not_busy = 0;
    do begin
      tick(); slots++;
      if (!d_ready && !mem_en) not_busy++;
    end while (!d_ready && slots < 40);
    n_run++; if (slots !== TO + 1) begin n_fail++; $display("FAIL timeout_cycle: ready after %0d cycles required %0d", slots, TO + 1); end
    n_run++; if ({d_ready, d_error, mem_en, i_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL timeout_flags: ready/error/mem_en/i_ready got %b required 1100", {d_ready, d_error, mem_en, i_ready});
    end
    n_run++; if ({not_busy, d_rdata} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL timeout_busy_rdata: idle cycles %0d rdata %h required 0/0", not_busy, d_rdata);
    end
    d_en = 1'b0;
    tick();
    n_run++; if ({d_ready, d_error} !== 2'b00) begin n_fail++; $display("FAIL timeout_pulse: got %b required 00", {d_ready, d_error}); end
    mem_fixed_lat = 0;
    d_en = 1'b1; d_addr = 8'h15;
    tick(); tick();
    n_run++; if ({d_ready, d_error, d_rdata} !== {2'b10, ref_mem[8'h15]}) begin
      n_fail++; $display("FAIL timeout_next: ready/error/data got %b/%b/%h required 1/0/%h", d_ready, d_error, d_rdata, ref_mem[8'h15]);
    end
    d_en = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    do_reset();
    mem_fixed_lat = 1_000_000;
    d_en = 1'b1; d_addr = 8'h14; d_rw = 4'b0000;
    tick();
    bad = 0;
    for (int s = 0; s < 40; s++) begin
      if (d_ready || d_error || i_error || !mem_en) bad++;
      tick();
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL no_timeout_wait: %0d bad cycles required 0", bad); end
    d_en = 1'b0;
    do_reset();
  endtask
`endif

  task automatic rand_requester(input int port);
    int          gap, waited;
    bit          got;
    logic [7:0]  a;
    logic [3:0]  m;
    logic [31:0] wd, exp_d, rd;
    logic        err;
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      a  = {port[0], 4'b0000, 3'($urandom_range(0, 7))};
      m  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      wd = $urandom;
      exp_d = ref_mem[a];
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      if (port == 0) begin i_en = 1'b1; i_addr = a; i_wdata = wd; i_rw = m; end
      else           begin d_en = 1'b1; d_addr = a; d_wdata = wd; d_rw = m; end
      got = 1'b0; waited = 0;
      while (!got && waited < 40) begin
        tick(); waited++;
        got = (port == 0) ? i_ready : d_ready;
      end
      rd  = (port == 0) ? i_rdata : d_rdata;
      err = (port == 0) ? i_error : d_error;
      n_run++;
      if (!got) begin
        n_fail++; $display("FAIL rand_wait_p%0d: no ready within 40 cycles, required ready", port);
      end else if ({err, rd} !== {1'b0, exp_d}) begin
        n_fail++; $display("FAIL rand_data_p%0d: addr %h error/data got %b/%h required 0/%h", port, a, err, rd, exp_d);
      end
      if (port == 0) i_en = 1'b0; else d_en = 1'b0;
    end
  endtask

  task automatic test_random();
    do_reset();
    mem_fixed_lat = -1;
    mon_en = 1'b1;
    fork
      rand_requester(0);
      rand_requester(1);
    join
    tick();
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_en = 1'b0; i_addr = '0; i_wdata = '0; i_rw = '0;
    d_en = 1'b0; d_addr = '0; d_wdata = '0; d_rw = '0;
    mem_fixed_lat = 0;
    mon_en = 1'b0;
    mon_last = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem_arr[a] = init_word(a);
      ref_mem[a] = init_word(a);
    end
    test_reset();
    test_single_read();
    test_latency();
    test_tie();
    test_write();
    test_withdraw();
    test_alternation();
    test_reset_abort();
`ifdef ELBETH_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
